// File: rtl/blaster_pkg.sv
// Shared definitions for the FT245-style bridge and the USB-Blaster JTAG engine top level.
package blaster_pkg;

  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned DEFAULT_RX_DEPTH = 64;
  localparam int unsigned DEFAULT_TX_DEPTH = 64;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_ACTIVE  = 2'd1,
    RD_RECOVER = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_ACTIVE  = 2'd1,
    WR_RECOVER = 2'd2
  } wr_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; head is read straight from the storage flops.
module byte_fifo
  import blaster_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [BYTE_W-1:0]       wdata,
  input  logic                    pop,
  output logic [BYTE_W-1:0]       head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  assign head  = mem[rptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/ft245_emu.sv
// FT245 asynchronous-FIFO pin emulation for the JTAG engine, backed by two on-chip byte FIFOs
// that the USB core fills and drains through valid/ready streams.
module ft245_emu
  import blaster_pkg::*;
#(
  parameter int unsigned RX_DEPTH = DEFAULT_RX_DEPTH,
  parameter int unsigned TX_DEPTH = DEFAULT_TX_DEPTH
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              nRXF,
  output logic              nTXE,
  input  logic              nRD,
  input  logic              WR,
  inout  wire  [BYTE_W-1:0] D,
  output logic              rx_underrun,
  output logic              tx_overrun
);

  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;

  rd_state_t         rd_state;
  rd_state_t         rd_next;
  wr_state_t         wr_state;
  wr_state_t         wr_next;

  logic              nrd_q;
  logic              wr_q;
  logic              nrxf_next;
  logic              ntxe_next;
  logic              rx_pop;
  logic              tx_push;
  logic              underrun_set;
  logic              overrun_set;

  logic [BYTE_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic [RX_CW-1:0]  rx_count;
  logic              tx_full;
  logic              tx_empty;
  logic [TX_CW-1:0]  tx_count;

  logic              d_en;
  logic [BYTE_W-1:0] d_out;

  // Host -> engine
  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (rx_valid && rx_ready),
    .wdata (rx_data),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Engine -> host; D is sampled in the same cycle the write strobe falls
  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (tx_push),
    .wdata (D),
    .pop   (tx_valid && tx_ready),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign rx_ready = nRST && !rx_full;
  assign tx_valid = !tx_empty;

  // Bus is only driven while the engine holds its read strobe low inside a read.
  assign d_en  = (rd_state == RD_ACTIVE) && !nRD;
  assign d_out = rx_empty ? 8'h00 : rx_head;
  assign D     = d_en ? d_out : 8'hzz;

  always_comb begin
    rd_next      = rd_state;
    nrxf_next    = 1'b1;
    rx_pop       = 1'b0;
    underrun_set = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (!nRD) rd_next = RD_ACTIVE;
        else      nrxf_next = rx_empty;
      end
      RD_ACTIVE: begin
        if (nRD && !nrd_q) begin
          rd_next = RD_RECOVER;
          if (rx_empty) underrun_set = 1'b1;
          else          rx_pop       = 1'b1;
        end
      end
      RD_RECOVER: rd_next = RD_IDLE;
      default:    rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_next     = wr_state;
    ntxe_next   = 1'b1;
    tx_push     = 1'b0;
    overrun_set = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (WR) wr_next   = WR_ACTIVE;
        else    ntxe_next = tx_full;
      end
      WR_ACTIVE: begin
        if (wr_q && !WR) begin
          wr_next = WR_RECOVER;
          if (tx_full) overrun_set = 1'b1;
          else         tx_push     = 1'b1;
        end
      end
      WR_RECOVER: wr_next = WR_IDLE;
      default:    wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_state    <= RD_IDLE;
      wr_state    <= WR_IDLE;
      nrd_q       <= 1'b1;
      wr_q        <= 1'b0;
      nRXF        <= 1'b1;
      nTXE        <= 1'b1;
      rx_underrun <= 1'b0;
      tx_overrun  <= 1'b0;
    end else begin
      rd_state    <= rd_next;
      wr_state    <= wr_next;
      nrd_q       <= nRD;
      wr_q        <= WR;
      nRXF        <= nrxf_next;
      nTXE        <= ntxe_next;
      rx_underrun <= rx_underrun || underrun_set;
      tx_overrun  <= tx_overrun || overrun_set;
    end
  end

  // Occupancy invariants of both FIFOs
  a_rx_bound: assert property (@(posedge CLK) disable iff (!nRST)
    (rx_count <= RX_CW'(RX_DEPTH)) && ((rx_count == '0) == rx_empty));
  a_tx_bound: assert property (@(posedge CLK) disable iff (!nRST)
    (tx_count <= TX_CW'(TX_DEPTH)) && ((tx_count == '0) == tx_empty));

endmodule

// File: tb/tb_ft245_emu.sv
// Self-checking bench for ft245_emu: directed engine-protocol scenarios plus a randomized mix,
// compared against queue-based models of both FIFOs and the sticky error flags.
module tb_ft245_emu;

  localparam int unsigned RXD = 16;
  localparam int unsigned TXD = 16;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       nrxf;
  logic       ntxe;
  logic       nrd;
  logic       wr;
  wire  [7:0] d;
  logic       rx_underrun;
  logic       tx_overrun;
  logic       d_drv;
  logic [7:0] d_val;

  int checks = 0;
  int passed = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       exp_under;
  logic       exp_over;

  assign d = d_drv ? d_val : 8'hzz;

  always #5 clk = ~clk;

  ft245_emu #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .CLK         (clk),
    .nRST        (nrst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .nRXF        (nrxf),
    .nTXE        (ntxe),
    .nRD         (nrd),
    .WR          (wr),
    .D           (d),
    .rx_underrun (rx_underrun),
    .tx_overrun  (tx_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    rx_q.delete();
    tx_q.delete();
    exp_under = 1'b0;
    exp_over  = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    if (rx_q.size() < RXD) rx_q.push_back(b);
  endtask

  // Engine read: nRD low for low_cycles clocks, then high; follows through recovery.
  task automatic engine_read(input int low_cycles);
    logic [7:0] exp_d;
    exp_d = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    nrd = 1'b0;
    for (int i = 0; i < low_cycles; i++) begin
      tick();
      checks++; if (dut.d_en !== 1'b1) $display("FAIL rd_drive got %b want 1", dut.d_en); else passed++;
      checks++; if (d !== exp_d) $display("FAIL rd_data got %h want %h", d, exp_d); else passed++;
      checks++; if (nrxf !== 1'b1) $display("FAIL rd_nrxf_busy got %b want 1", nrxf); else passed++;
    end
    nrd = 1'b1;
    tick();
    if (rx_q.size() == 0) exp_under = 1'b1;
    else                  void'(rx_q.pop_front());
    checks++; if (dut.d_en !== 1'b0) $display("FAIL rd_release got %b want 0", dut.d_en); else passed++;
    checks++; if (rx_underrun !== exp_under) $display("FAIL rd_underrun got %b want %b", rx_underrun, exp_under); else passed++;
    checks++; if (nrxf !== 1'b1) $display("FAIL rd_nrxf_pop got %b want 1", nrxf); else passed++;
    tick();
    checks++; if (nrxf !== 1'b1) $display("FAIL rd_nrxf_recover got %b want 1", nrxf); else passed++;
    tick();
    checks++; if (nrxf !== (rx_q.size() == 0)) $display("FAIL rd_nrxf_idle got %b want %b", nrxf, rx_q.size() == 0); else passed++;
  endtask

  // Engine write: WR high for two clocks, D presented in the falling cycle.
  task automatic engine_write(input logic [7:0] b);
    wr = 1'b1;
    tick();
    checks++; if (ntxe !== 1'b1) $display("FAIL wr_ntxe_busy got %b want 1", ntxe); else passed++;
    tick();
    wr    = 1'b0;
    d_drv = 1'b1;
    d_val = b;
    tick();
    d_drv = 1'b0;
    if (tx_q.size() < TXD) tx_q.push_back(b);
    else                   exp_over = 1'b1;
    checks++; if (tx_valid !== 1'b1) $display("FAIL wr_tx_valid got %b want 1", tx_valid); else passed++;
    checks++; if (tx_data !== tx_q[0]) $display("FAIL wr_tx_data got %h want %h", tx_data, tx_q[0]); else passed++;
    checks++; if (tx_overrun !== exp_over) $display("FAIL wr_overrun got %b want %b", tx_overrun, exp_over); else passed++;
    tick();
    checks++; if (ntxe !== 1'b1) $display("FAIL wr_ntxe_recover got %b want 1", ntxe); else passed++;
    tick();
    checks++; if (ntxe !== (tx_q.size() == TXD)) $display("FAIL wr_ntxe_idle got %b want %b", ntxe, tx_q.size() == TXD); else passed++;
  endtask

  task automatic tx_pop();
    checks++; if (tx_valid !== (tx_q.size() != 0)) $display("FAIL tx_valid got %b want %b", tx_valid, tx_q.size() != 0); else passed++;
    if (tx_q.size() != 0) begin
      checks++; if (tx_data !== tx_q[0]) $display("FAIL tx_head got %h want %h", tx_data, tx_q[0]); else passed++;
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick();
    tick();
    checks++; if (rx_ready !== 1'b0) $display("FAIL rst_rx_ready got %b want 0", rx_ready); else passed++;
    checks++; if (nrxf !== 1'b1) $display("FAIL rst_nrxf got %b want 1", nrxf); else passed++;
    checks++; if (ntxe !== 1'b1) $display("FAIL rst_ntxe got %b want 1", ntxe); else passed++;
    checks++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid got %b want 0", tx_valid); else passed++;
    checks++; if ({rx_underrun, tx_overrun} !== 2'b00) $display("FAIL rst_flags got %b want 00", {rx_underrun, tx_overrun}); else passed++;
    checks++; if (dut.d_en !== 1'b0) $display("FAIL rst_bus got %b want 0", dut.d_en); else passed++;
    nrst = 1'b1;
    tick();
    checks++; if (ntxe !== 1'b0) $display("FAIL post_rst_ntxe got %b want 0", ntxe); else passed++;
    checks++; if (nrxf !== 1'b1) $display("FAIL post_rst_nrxf got %b want 1", nrxf); else passed++;
    checks++; if (rx_ready !== 1'b1) $display("FAIL post_rst_rx_ready got %b want 1", rx_ready); else passed++;
    rx_q.delete();
    tx_q.delete();
    exp_under = 1'b0;
    exp_over  = 1'b0;
  endtask

  task automatic test_single_read();
    rx_push(8'hA5);
    checks++; if (nrxf !== 1'b1) $display("FAIL lat_nrxf_1 got %b want 1", nrxf); else passed++;
    tick();
    checks++; if (nrxf !== 1'b0) $display("FAIL lat_nrxf_2 got %b want 0", nrxf); else passed++;
    engine_read(3);
    tick();
    checks++; if (nrxf !== 1'b1) $display("FAIL single_empty got %b want 1", nrxf); else passed++;
  endtask

  task automatic test_back_to_back();
    rx_push(8'h11);
    rx_push(8'h22);
    rx_push(8'h33);
    tick();
    checks++; if (nrxf !== 1'b0) $display("FAIL b2b_ready got %b want 0", nrxf); else passed++;
    for (int i = 0; i < 3; i++) engine_read(3);
  endtask

  task automatic test_underrun();
    engine_read(2);
    rx_push(8'h5A);
    tick();
    engine_read(1);
  endtask

  task automatic test_write();
    engine_write(8'h3C);
    tx_pop();
    tx_pop();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < int'(TXD); i++) engine_write(8'($urandom));
    checks++; if (ntxe !== 1'b1) $display("FAIL ovr_full_ntxe got %b want 1", ntxe); else passed++;
    engine_write(8'hEE);
    for (int i = 0; i <= int'(TXD); i++) tx_pop();
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    for (int i = 0; i < 5; i++) rx_push(8'(8'h40 + i));
    tick();
    nrd = 1'b0;
    tick();
    checks++; if (dut.d_en !== 1'b1) $display("FAIL mid_drive got %b want 1", dut.d_en); else passed++;
    nrst = 1'b0;
    tick();
    checks++; if (dut.d_en !== 1'b0) $display("FAIL mid_bus got %b want 0", dut.d_en); else passed++;
    checks++; if (nrxf !== 1'b1) $display("FAIL mid_nrxf got %b want 1", nrxf); else passed++;
    nrst = 1'b1;
    nrd  = 1'b1;
    rx_q.delete();
    tx_q.delete();
    exp_under = 1'b0;
    exp_over  = 1'b0;
    tick();
    checks++; if (rx_ready !== 1'b1) $display("FAIL mid_rx_ready got %b want 1", rx_ready); else passed++;
    tick();
    tick();
    checks++; if (nrxf !== 1'b1) $display("FAIL mid_empty got %b want 1", nrxf); else passed++;
    checks++; if (rx_underrun !== 1'b0) $display("FAIL mid_underrun got %b want 0", rx_underrun); else passed++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(3, 0))
        0:       rx_push(8'($urandom));
        1:       engine_read(int'($urandom_range(3, 1)));
        2:       engine_write(8'($urandom));
        default: tx_pop();
      endcase
    end
  endtask

  initial begin
    nrst     = 1'b0;
    nrd      = 1'b1;
    wr       = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    d_drv    = 1'b0;
    d_val    = 8'h00;
    exp_under = 1'b0;
    exp_over  = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_underrun();
    test_write();
    test_overrun();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
